// File: rtl/airi5c_fpu_result_buffer.sv
// FPU result buffer: captures single-cycle sub-unit result pulses into a FIFO for writeback.
// Latency 1 cycle from empty (0 with AIRI5C_FPU_RESULT_BYPASS_EN defined); strictly in order.
// Holds results while out_ack is low; drops and flags err_overflow when full with no pop.
module airi5c_fpu_result_buffer #(
    parameter int N_UNITS = 4,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   kill,
    input  logic [N_UNITS-1:0]     unit_ready,
    input  logic [32*N_UNITS-1:0]  unit_result,
    input  logic [5*N_UNITS-1:0]   unit_flags,
    output logic                   out_valid,
    output logic [31:0]            out_data,
    output logic [4:0]             out_flags,
    input  logic                   out_ack,
    output logic                   full,
    output logic                   busy,
    output logic                   err_overflow,
    output logic                   err_collision
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   data_mem  [DEPTH];
    logic [4:0]    flags_mem [DEPTH];

    logic          push;
    logic          pop;
    logic          wr_en;
    logic          collision;
    logic          stored_valid;
    logic          bypass_vld;
    logic          bypass_take;
    logic [31:0]   sel_result;
    logic [4:0]    sel_flags;

    // Scan downward so the lowest set index wins.
    always_comb begin
        sel_result = '0;
        sel_flags  = '0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (unit_ready[i]) begin
                sel_result = unit_result[32*i +: 32];
                sel_flags  = unit_flags[5*i +: 5];
            end
        end
    end

    assign push         = |unit_ready;
    assign collision    = |(unit_ready & (unit_ready - 1'b1));
    assign stored_valid = (count != '0);
    assign full         = (count == (AW+1)'(DEPTH));
    assign busy         = stored_valid;

`ifdef AIRI5C_FPU_RESULT_BYPASS_EN
    assign bypass_vld  = ~stored_valid & push & ~kill;
    assign bypass_take = bypass_vld & out_ack;
`else
    assign bypass_vld  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign out_valid = stored_valid | bypass_vld;
    assign pop       = stored_valid & out_ack;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal then.
    assign wr_en     = push & ~bypass_take & (~full | pop) & ~kill;

    always_comb begin
        out_data  = '0;
        out_flags = '0;
        if (stored_valid) begin
            out_data  = data_mem[rd_ptr];
            out_flags = flags_mem[rd_ptr];
        end else if (bypass_vld) begin
            out_data  = sel_result;
            out_flags = sel_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr]  <= sel_result;
            flags_mem[wr_ptr] <= sel_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_overflow  <= 1'b0;
            err_collision <= 1'b0;
        end else if (kill) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_overflow  <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            if (collision) begin
                err_collision <= 1'b1;
            end
            if (push & full & ~pop) begin
                err_overflow <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/airi5c_fpu_result_buffer.md
Name: airi5c_fpu_result_buffer

Overview:
- Sits directly downstream of the FPU sub-units (sign modifier, adder, multiplier, converter, ...).
- Captures their single-cycle result pulses (ready + 32-bit float + 5-bit exception flags) into a small FIFO.
- Presents results to the core writeback stage with a valid/ack handshake, so no result is lost while writeback stalls.
- Flushed by the same kill signal the sub-units receive.

Parameters:
- N_UNITS, 4, number of FPU sub-units feeding the buffer (1..8)
- DEPTH, 2, FIFO entries; power of two, >= 2

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- kill  input  1  synchronous flush of buffer contents and sticky errors
- unit_ready  input  N_UNITS  per-unit result-valid pulse; bit i belongs to unit i
- unit_result  input  32*N_UNITS  results; unit i occupies bits [32*i+31:32*i]
- unit_flags  input  5*N_UNITS  fflags {NV,DZ,OF,UF,NX}; unit i occupies bits [5*i+4:5*i]
- out_valid  output  1  head entry valid
- out_data  output  32  head entry result
- out_flags  output  5  head entry flags
- out_ack  input  1  writeback consumes head this cycle; ignored when out_valid=0
- full  output  1  count == DEPTH
- busy  output  1  count != 0
- err_overflow  output  1  sticky: a result arrived while full and no pop occurred
- err_collision  output  1  sticky: more than one unit_ready bit high in one cycle

Behaviour:
- Reset (async, reset=1):
  - pointers and count = 0; out_valid=0, full=0, busy=0.
  - out_data=32'h0, out_flags=5'h0; err_overflow=0, err_collision=0.
  - Storage array contents are don't-care but must never be visible on the outputs.
- Write selection:
  - push = |unit_ready.
  - Source is the lowest set index i of unit_ready; that unit's result and flags are written.
  - Multi-hot unit_ready: lowest index is still written, and err_collision is set (sticky).
- Pop: pop = out_valid & out_ack.
- Count update each cycle, without bypass:
  - push & !pop & !full: count+1, write at wr_ptr.
  - pop & !push: count-1, rd_ptr advances.
  - push & pop: count unchanged, both pointers advance. This is legal even when full: the read frees a slot in the same cycle.
  - push & full & !pop: entry dropped, pointers and count unchanged, err_overflow set (sticky).
- Pointers: log2(DEPTH) bits, wrap from DEPTH-1 to 0. count is log2(DEPTH)+1 bits.
- Outputs:
  - out_valid = (count != 0).
  - out_data and out_flags are driven from storage[rd_ptr] when out_valid=1, and are all-zero when out_valid=0.
  - full and busy are combinational from count.
- Latency: a result pulsed in cycle t appears on out_valid in cycle t+1 when the FIFO is empty.
- Ordering: strictly FIFO, never reordered.
- kill (synchronous; priority over push and pop in the same cycle):
  - pointers and count = 0; both sticky errors cleared.
  - Any unit_ready in the kill cycle is discarded.
  - out_valid=0 from the next cycle.
- reset mid-operation: all entries are lost immediately (async); no partial state survives.

Optional Feature:
- Macro: AIRI5C_FPU_RESULT_BYPASS_EN.
- Defined:
  - When count==0 and push, the selected result is driven combinationally on out_valid/out_data/out_flags in the same cycle.
  - If out_ack is also high that cycle, the result is consumed and not written; count stays 0.
  - If out_ack is low, the result is written normally.
  - Latency from empty is 0 cycles.
  - Collision/overflow rules are unchanged.
- Not defined: no combinational path from unit_* to out_*; latency from empty is 1 cycle as above.

Test Plan:
- Reset, then idle -> out_valid=0, out_data=0, busy=0, full=0, both errors 0.
- Unit 0 pulses 32'h3F800000 / flags 5'b00001 in cycle t, out_ack=0 -> out_valid=1 with that data/flags from t+1 until ack; one cycle after the ack cycle, out_valid=0.
- DEPTH=2, out_ack=0, units 1,2,3 pulse 32'h1,32'h2,32'h3 in consecutive cycles -> full=1 after the second; third dropped, err_overflow=1; acks return 32'h1 then 32'h2.
- Full FIFO, push 32'hC0000000 with out_ack=1 same cycle -> count stays 2, head becomes the second entry, new value is last, no overflow.
- unit_ready=4'b0110 with results 32'hA/32'hB on units 1/2 -> 32'hA stored, err_collision=1; kill next cycle -> out_valid=0, err_collision=0, busy=0.
- With AIRI5C_FPU_RESULT_BYPASS_EN, empty FIFO, unit 3 pulses 32'h40490FDB with out_ack=1 -> out_valid=1 and data in the same cycle, busy stays 0 the next cycle.
